// File: rtl/conv_window_feeder_if.sv
// conv_window_feeder_if
// Bundles every non-clock, non-reset signal of the convolution window feeder.
//   kernel_we / kernel_addr / kernel_data : weight write port (driven by master)
//   kernel_busy                           : weight writes currently ignored
//   pix_valid / pix_sof / pix_data        : row-major pixel stream (driven by master)
//   pix_ready                             : feeder accepts a pixel this cycle
//   multiplier_output                     : flattened K*K pixel window
//   multiplicand_output                   : flattened K*K kernel weights
//   mStart                                : multiply start, one bit per tap
//   cReady                                : processor result ready (driven by master)
//   window_count / frame_done             : per-frame progress
// The master modport is the environment (pixel source, kernel loader,
// processor); the slave modport is the feeder itself.
interface conv_window_feeder_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int ADDR_WIDTH  = $clog2(KERNEL_SIZE * KERNEL_SIZE)
);
    localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int BUS_W = TAPS * DATA_WIDTH;

    logic                  kernel_we;
    logic [ADDR_WIDTH-1:0] kernel_addr;
    logic [DATA_WIDTH-1:0] kernel_data;
    logic                  kernel_busy;

    logic                  pix_valid;
    logic                  pix_sof;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_ready;

    logic [BUS_W-1:0]      multiplier_output;
    logic [BUS_W-1:0]      multiplicand_output;
    logic [TAPS-1:0]       mStart;
    logic                  cReady;

    logic [15:0]           window_count;
    logic                  frame_done;

    modport master (
        output kernel_we, kernel_addr, kernel_data,
        output pix_valid, pix_sof, pix_data,
        output cReady,
        input  kernel_busy, pix_ready,
        input  multiplier_output, multiplicand_output, mStart,
        input  window_count, frame_done
    );

    modport slave (
        input  kernel_we, kernel_addr, kernel_data,
        input  pix_valid, pix_sof, pix_data,
        input  cReady,
        output kernel_busy, pix_ready,
        output multiplier_output, multiplicand_output, mStart,
        output window_count, frame_done
    );
endinterface

// File: rtl/conv_window_feeder.sv
// conv_window_feeder
// Turns a row-major pixel stream into K x K sliding windows for the
// ma_int_32 convolution processor. K-1 line buffers hold the previous rows,
// a K x K register holds the current window, and a K x K register holds the
// kernel weights. Each complete window is presented on the flat buses with a
// one-cycle mStart pulse, after which the pixel stream is stalled until the
// processor answers with cReady.
// Ports:
//   clk   : single rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : conv_window_feeder_if slave modport (pixel stream, kernel
//           writes, window/weight buses, mStart/cReady, frame progress)
module conv_window_feeder #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8,
    parameter int ADDR_WIDTH  = $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
    input logic                 clk,
    input logic                 rst_n,
    conv_window_feeder_if.slave bus
);
    localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = $clog2(IMG_HEIGHT + 1);

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        ISSUE,
        WAIT
    } state_t;

    state_t                state;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic                  last_window;
    logic                  pix_ready_q;
    logic                  mstart_q;
    logic                  busy_q;
    logic                  frame_done_q;
    logic [15:0]           count_q;

    logic [DATA_WIDTH-1:0] window   [KERNEL_SIZE][KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] weights  [TAPS];
    logic [DATA_WIDTH-1:0] line_buf [KERNEL_SIZE-1][IMG_WIDTH];

    logic                  accept;
    logic [COL_W-1:0]      pos_col;
    logic [ROW_W-1:0]      pos_row;
    logic                  col_wrap;
    logic                  window_full;
    logic                  weight_write;
    logic [DATA_WIDTH-1:0] column [KERNEL_SIZE];

    // Position of the pixel being accepted: a start-of-frame pixel is
    // always (0,0) regardless of where the counters were. The new window
    // column is that pixel stacked under the same column of the K-1
    // buffered rows, oldest row first.
    always_comb begin
        accept       = (state == ACCEPT) && bus.pix_valid;
        pos_col      = bus.pix_sof ? '0 : col;
        pos_row      = bus.pix_sof ? '0 : row;
        col_wrap     = (pos_col == COL_LAST);
        window_full  = (pos_row >= ROW_FIRST_WIN) && (pos_col >= COL_FIRST_WIN);
        weight_write = ((state == IDLE) || (state == ACCEPT)) && bus.kernel_we &&
                       ({1'b0, bus.kernel_addr} < (ADDR_WIDTH + 1)'(TAPS));
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            column[r] = '0;
        end
        for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
            column[r] = line_buf[r][pos_col];
        end
        column[KERNEL_SIZE-1] = bus.pix_data;
    end

    // Line buffers act as a per-column shift register: each accepted pixel
    // pushes its column up by one row. They are never cleared; a window is
    // only issued once K full rows of the current frame have arrived.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < KERNEL_SIZE - 2; r++) begin
                line_buf[r][pos_col] <= line_buf[r+1][pos_col];
            end
            line_buf[KERNEL_SIZE-2][pos_col] <= bus.pix_data;
        end
    end

    // Control FSM with registered outputs, window register and weight
    // register. The window only shifts on an accepted pixel, so it stays
    // frozen for the whole ISSUE/WAIT handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            last_window  <= 1'b0;
            pix_ready_q  <= 1'b0;
            mstart_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            count_q      <= '0;
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    window[r][c] <= '0;
                end
            end
            for (int i = 0; i < TAPS; i++) begin
                weights[i] <= '0;
            end
        end else begin
            mstart_q     <= 1'b0;
            frame_done_q <= 1'b0;

            if (weight_write) begin
                weights[bus.kernel_addr] <= bus.kernel_data;
            end

            case (state)
                IDLE: begin
                    state       <= ACCEPT;
                    pix_ready_q <= 1'b1;
                end

                ACCEPT: begin
                    if (accept) begin
                        for (int r = 0; r < KERNEL_SIZE; r++) begin
                            for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                                window[r][c] <= window[r][c+1];
                            end
                            window[r][KERNEL_SIZE-1] <= column[r];
                        end
                        col <= col_wrap ? '0 : pos_col + 1'b1;
                        row <= col_wrap ? pos_row + 1'b1 : pos_row;
                        if (bus.pix_sof) begin
                            count_q <= '0;
                        end
                        if (window_full) begin
                            state       <= ISSUE;
                            pix_ready_q <= 1'b0;
                            mstart_q    <= 1'b1;
                            busy_q      <= 1'b1;
                            last_window <= (pos_row == ROW_LAST) && (pos_col == COL_LAST);
                        end
                    end
                end

                ISSUE: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (bus.cReady) begin
                        state       <= ACCEPT;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        if (count_q != 16'hFFFF) begin
                            count_q <= count_q + 16'd1;
                        end
                        // Row has already stepped past the last row when
                        // the final pixel was accepted; restart the frame.
                        if (last_window) begin
                            frame_done_q <= 1'b1;
                            row          <= '0;
                            col          <= '0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Flatten window and weights, element i = r*K + c in bits [i*DW +: DW].
    always_comb begin
        bus.multiplier_output   = '0;
        bus.multiplicand_output = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE; c++) begin
                bus.multiplier_output[(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH]   = window[r][c];
                bus.multiplicand_output[(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] = weights[r*KERNEL_SIZE+c];
            end
        end
    end

    assign bus.pix_ready    = pix_ready_q;
    assign bus.mStart       = {TAPS{mstart_q}};
    assign bus.kernel_busy  = busy_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.window_count = count_q;

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Upstream stage of the convolution processor (ma_int_32). It accepts a row-major pixel stream and builds K×K sliding windows using K-1 line buffers plus a K×K window register. It holds a K×K kernel weight register, presents both as the flat multiplier/multiplicand buses, and pulses mStart. It then stalls the pixel stream until the processor returns finalReady (cReady).

## Interface
- DATA_WIDTH, 32, bits per pixel and per weight
- KERNEL_SIZE, 3, window edge K
- IMG_WIDTH, 8, pixels per image row (must be ≥ K)
- IMG_HEIGHT, 8, rows per frame (must be ≥ K)
- ADDR_WIDTH, $clog2(KERNEL_SIZE*KERNEL_SIZE), kernel address width
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- kernel_we  in  1  weight write strobe
- kernel_addr  in  ADDR_WIDTH  weight index, 0 = top-left, row-major
- kernel_data  in  DATA_WIDTH  weight value
- kernel_busy  out  1  high in ISSUE/WAIT; weight writes ignored
- pix_valid  in  1  pixel present
- pix_sof  in  1  start of frame, qualified by pix_valid
- pix_data  in  DATA_WIDTH  pixel value
- pix_ready  out  1  feeder accepts pixel this cycle
- multiplier_output  out  K*K*DATA_WIDTH  window, element i at [(i+1)*DW-1 : i*DW]
- multiplicand_output  out  K*K*DATA_WIDTH  kernel weights, same packing
- mStart  out  K*K  multiply start, all bits identical
- cReady  in  1  processor result ready (finalReady)
- window_count  out  16  windows issued this frame
- frame_done  out  1  one-cycle pulse after last window of frame completes

## Operation
- States: IDLE, ACCEPT, ISSUE, WAIT. Reset → IDLE. IDLE → ACCEPT unconditionally next cycle.
- ACCEPT: pix_ready=1. A pixel is accepted when pix_valid&&pix_ready.
  - On accept, shift the pixel into the window's bottom-right and the line buffers. Advance col; at IMG_WIDTH-1 wrap col to 0 and increment row.
  - If row≥K-1 and col≥K-1 for the accepted pixel, go to ISSUE. Otherwise stay.
- pix_sof on an accepted pixel forces it to (row 0, col 0) and clears window_count. Line buffer contents are not cleared; stale data is never issued, because validity requires row≥K-1.
- ISSUE (1 cycle): mStart=all ones. Go to WAIT.
- WAIT: pix_ready=0. multiplier_output is held stable. On cReady, increment window_count and go to ACCEPT.
  - If the completed window was at (IMG_HEIGHT-1, IMG_WIDTH-1), pulse frame_done in the same cycle and wrap row/col to 0.
- Window element i=r*K+c: r=0 is the oldest row, c=0 is the oldest column. Weight i is paired unflipped (correlation).
- Kernel writes apply only in IDLE/ACCEPT. Writes to addr ≥ K*K are ignored.
- cReady outside WAIT is ignored.
- Pixels accepted in rows <K-1 or cols <K-1 only fill buffers.

## Timing
- Reset values:
  - pix_ready=0, mStart=0, kernel_busy=0, frame_done=0, window_count=0.
  - multiplier_output=0, multiplicand_output=0 (weights cleared).
- pix_ready is high from the second cycle after rst_n rises.
- Window-completing pixel accepted at cycle t: multiplier_output valid at t+1, mStart high at t+1 only, kernel_busy high at t+1.
- cReady seen at cycle u: pix_ready=1 and kernel_busy=0 at u+1. window_count and frame_done are registered, visible at u+1.
- Throughput: one window per (processor latency + 2) cycles. Non-issuing pixels are accepted 1/cycle.
- rst_n low mid-WAIT: next cycle is IDLE and all outputs take reset values. A late cReady is ignored.
- window_count saturates at 16'hFFFF.

## Test plan
- 4×4 image, K=3, all weights 1, pixels 1..16 with sof on pixel 1. The first mStart comes one cycle after pixel 11. multiplier_output elements are 1,2,3,5,6,7,9,10,11. multiplicand_output is all 1.
- Same frame, cReady returned 5 cycles after each mStart. Exactly 4 mStart pulses (after pixels 11,12,15,16). pix_ready stays 0 between each mStart and its cReady. frame_done pulses once. window_count=4.
- Write weight 7 to addr 4 during ACCEPT: element 4 of multiplicand_output=7. Write addr 9 or write during WAIT: no change.
- Assert sof on pixel 6 of a frame, then stream 16 pixels. No mStart before the 11th post-sof pixel, and window_count restarts at 0.
- Assert rst_n=0 for 1 cycle while in WAIT. All outputs read their reset values. Then 2 cycles later pix_ready=1. A cReady after reset causes no window_count change.
- Hold pix_valid low for 3 cycles mid-row: there is no spurious mStart and window contents match the gap-free reference.
